muldiv_wb_unit: RTL and testbench

- Iterative multiply/divide execution unit for the single-cycle core's M-extension path.
- Consumes the two register-file read ports (FR_Rdata_1 / FR_Rdata_2) as operands.
- Produces the register-file write port signals (FR_Waddr, FR_WE, FR_Wdata) one result at a time.
- Stalls the core through busy while a radix-2 shift-add multiply or restoring divide runs.

---
 rtl/muldiv_wb_unit.sv | 155 +++++++++++++++
 tb/tb_muldiv_wb_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_wb_unit.sv
// Iterative radix-2 multiply / restoring divide unit for the M-extension path.
// Takes register-file read data as operands and writes one result back through the write port.
module muldiv_wb_unit #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  input  logic [AW-1:0]    rd_addr,
  output logic             busy,
  output logic             done,
  output logic             wb_we,
  output logic [AW-1:0]    wb_addr,
  output logic [WIDTH-1:0] wb_data
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MULHU = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_WB   = 2'b10
  } state_t;

  state_t             state_q;
  logic [1:0]         op_q;
  logic [AW-1:0]      rd_q;
  logic [WIDTH-1:0]   opb_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   quo_q;
  logic [CW-1:0]      cnt_q;
  logic               busy_q;
  logic               done_q;
  logic               we_q;
  logic [AW-1:0]      waddr_q;
  logic [WIDTH-1:0]   wdata_q;

  logic [WIDTH:0]     add_sum;
  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   rem_d;
  logic [WIDTH-1:0]   quo_d;
  logic [WIDTH-1:0]   result_d;

  // One iteration of each algorithm; the FSM commits only the one selected by op_q.
  always_comb begin
    add_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    acc_d   = {add_sum, acc_q[WIDTH-1:1]};

    rem_sh  = {rem_q, quo_q[WIDTH-1]};
    trial   = rem_sh - {1'b0, opb_q};
    if (!trial[WIDTH]) begin
      rem_d = trial[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_d = rem_sh[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b0};
    end

    case (op_q)
      OP_MUL:   result_d = acc_d[WIDTH-1:0];
      OP_MULHU: result_d = acc_d[2*WIDTH-1:WIDTH];
      OP_DIVU:  result_d = quo_d;
      default:  result_d = rem_d;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      rd_q    <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      done_q <= 1'b0;
      we_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q   <= op;
            rd_q   <= rd_addr;
            opb_q  <= rs2_data;
            acc_q  <= {{WIDTH{1'b0}}, rs1_data};
            rem_q  <= '0;
            quo_q  <= rs1_data;
            cnt_q  <= CNT_LOAD;
            busy_q <= 1'b1;
            // Divide by zero has a fixed answer, so skip the iterations entirely.
            if (op[1] && (rs2_data == '0)) begin
              state_q <= S_WB;
              done_q  <= 1'b1;
              we_q    <= (rd_addr != '0);
              waddr_q <= rd_addr;
              wdata_q <= op[0] ? rs1_data : {WIDTH{1'b1}};
            end else begin
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (op_q[1]) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
          end else begin
            acc_q <= acc_d;
          end
          if (cnt_q == '0) begin
            state_q <= S_WB;
            done_q  <= 1'b1;
            we_q    <= (rd_q != '0);
            waddr_q <= rd_q;
            wdata_q <= result_d;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_WB: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign wb_we   = we_q;
  assign wb_addr = waddr_q;
  assign wb_data = wdata_q;

endmodule

// File: tb/tb_muldiv_wb_unit.sv
// Scoreboard bench for muldiv_wb_unit: expected write-backs are queued at issue
// from a behavioural arithmetic model and compared when done pulses.
module tb_muldiv_wb_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic [4:0]  rd_addr = '0;
  logic        busy, done, wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  addr;
    logic        we;
    int          lat;
  } exp_t;
  exp_t sb[$];

  muldiv_wb_unit #(.WIDTH(32), .AW(5)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_addr(rd_addr),
    .busy(busy), .done(done), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (o)
      2'b00:   return p[31:0];
      2'b01:   return p[63:32];
      2'b10:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Drives one start pulse; returns #1 after the accepting edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    exp_t e;
    @(negedge clk);
    start = 1'b1; op = o; rs1_data = a; rs2_data = b; rd_addr = rd;
    e.data = model(o, a, b);
    e.addr = rd;
    e.we   = (rd != 0);
    e.lat  = (o[1] && b == 0) ? 0 : 32;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Waits (bounded) for done; lat counts edges after the accepting edge.
  task automatic wait_wb(input int lat0, output bit found, output int lat, output int busy_n,
                         output logic [31:0] data, output logic [4:0] addr, output logic we,
                         output logic done_nx, output logic we_nx, output logic busy_nx,
                         output logic [31:0] data_nx);
    int i;
    found = 0; lat = -1; busy_n = 0; i = 0;
    data = 'x; addr = 'x; we = 'x; done_nx = 'x; we_nx = 'x; busy_nx = 'x; data_nx = 'x;
    while (!found && i <= 100) begin
      if (busy) busy_n++;
      if (done === 1'b1) begin
        found = 1; lat = lat0 + i; data = wb_data; addr = wb_addr; we = wb_we;
      end else begin
        @(posedge clk); #1;
        i++;
      end
    end
    if (found) begin
      @(posedge clk); #1;
      done_nx = done; we_nx = wb_we; busy_nx = busy; data_nx = wb_data;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    n_tests++; if (wb_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got=%b exp=0", wb_we); end
    n_tests++; if (wb_addr !== 5'd0) begin n_fail++; $display("FAIL reset_addr got=%0d exp=0", wb_addr); end
    n_tests++; if (wb_data !== 32'd0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", wb_data); end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_mul_latency();
    bit found; int lat, bn; logic [31:0] d, dn; logic [4:0] a; logic w, dnx, wnx, bnx; exp_t e;
    issue(2'b00, 32'd7, 32'd6, 5'd3);
    wait_wb(0, found, lat, bn, d, a, w, dnx, wnx, bnx, dn);
    e = sb.pop_front();
    n_tests++; if (!found) begin n_fail++; $display("FAIL mul_timeout no done within bound"); end
    n_tests++; if (lat !== e.lat) begin n_fail++; $display("FAIL mul_latency got=%0d exp=%0d", lat, e.lat); end
    n_tests++; if (bn !== 33) begin n_fail++; $display("FAIL mul_busy_cycles got=%0d exp=33", bn); end
    n_tests++; if (d !== e.data || e.data !== 32'd42) begin n_fail++; $display("FAIL mul_data got=%0d exp=42", d); end
    n_tests++; if (a !== e.addr) begin n_fail++; $display("FAIL mul_addr got=%0d exp=%0d", a, e.addr); end
    n_tests++; if (w !== 1'b1) begin n_fail++; $display("FAIL mul_we got=%b exp=1", w); end
    n_tests++; if (dnx !== 1'b0) begin n_fail++; $display("FAIL mul_done_pulse got=%b exp=0", dnx); end
    n_tests++; if (wnx !== 1'b0) begin n_fail++; $display("FAIL mul_we_drop got=%b exp=0", wnx); end
    n_tests++; if (bnx !== 1'b0) begin n_fail++; $display("FAIL mul_busy_drop got=%b exp=0", bnx); end
  endtask

  // Table-driven back-to-back issue; each start lands in the first IDLE cycle after WB.
  task automatic test_table(input string name, input int n, input logic [1:0] ops[4],
                            input logic [31:0] as[4], input logic [31:0] bs[4], input logic [4:0] rds[4]);
    bit found; int lat, bn; logic [31:0] d, dn; logic [4:0] a; logic w, dnx, wnx, bnx; exp_t e;
    for (int k = 0; k < n; k++) begin
      issue(ops[k], as[k], bs[k], rds[k]);
      wait_wb(0, found, lat, bn, d, a, w, dnx, wnx, bnx, dn);
      e = sb.pop_front();
      n_tests++; if (!found) begin n_fail++; $display("FAIL %s_%0d_timeout no done", name, k); end
      n_tests++; if (lat !== e.lat) begin n_fail++; $display("FAIL %s_%0d_latency got=%0d exp=%0d", name, k, lat, e.lat); end
      n_tests++; if (d !== e.data) begin n_fail++; $display("FAIL %s_%0d_data got=%h exp=%h", name, k, d, e.data); end
      n_tests++; if (a !== e.addr) begin n_fail++; $display("FAIL %s_%0d_addr got=%0d exp=%0d", name, k, a, e.addr); end
      n_tests++; if (w !== e.we) begin n_fail++; $display("FAIL %s_%0d_we got=%b exp=%b", name, k, w, e.we); end
      n_tests++; if (dn !== e.data) begin n_fail++; $display("FAIL %s_%0d_data_hold got=%h exp=%h", name, k, dn, e.data); end
      n_tests++; if (dnx !== 1'b0) begin n_fail++; $display("FAIL %s_%0d_done_pulse got=%b exp=0", name, k, dnx); end
    end
  endtask

  task automatic test_ignore_start();
    bit found; int lat, bn; logic [31:0] d, dn; logic [4:0] a; logic w, dnx, wnx, bnx; exp_t e;
    int extra;
    issue(2'b00, 32'd5, 32'd5, 5'd4);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      start = 1'b1; op = 2'b10; rs1_data = $urandom; rs2_data = 32'd0; rd_addr = 5'd9;
      @(posedge clk); #1;
      start = 1'b0;
    end
    wait_wb(5, found, lat, bn, d, a, w, dnx, wnx, bnx, dn);
    e = sb.pop_front();
    n_tests++; if (!found) begin n_fail++; $display("FAIL ignore_timeout no done"); end
    n_tests++; if (lat !== e.lat) begin n_fail++; $display("FAIL ignore_latency got=%0d exp=%0d", lat, e.lat); end
    n_tests++; if (d !== e.data) begin n_fail++; $display("FAIL ignore_data got=%0d exp=%0d", d, e.data); end
    n_tests++; if (a !== e.addr) begin n_fail++; $display("FAIL ignore_addr got=%0d exp=%0d", a, e.addr); end
    extra = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    n_tests++; if (extra !== 0) begin n_fail++; $display("FAIL ignore_no_restart got=%0d exp=0", extra); end
  endtask

  task automatic test_abort();
    bit found; int lat, bn; logic [31:0] d, dn; logic [4:0] a; logic w, dnx, wnx, bnx; exp_t e;
    int writes;
    issue(2'b00, 32'h1111, 32'h2222, 5'd6);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = (k % 3 == 0); op = 2'b10; rs2_data = 32'd0; rd_addr = 5'd7;
      @(posedge clk); #1;
      start = 1'b0;
      n_tests++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL abort_pre_%0d busy=%b done=%b exp busy=1 done=0", k, busy, done); end
    end
    #2 reset = 1'b1;
    #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%b exp=0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done got=%b exp=0", done); end
    n_tests++; if (wb_we !== 1'b0) begin n_fail++; $display("FAIL abort_we got=%b exp=0", wb_we); end
    n_tests++; if (wb_data !== 32'd0) begin n_fail++; $display("FAIL abort_data got=%h exp=0", wb_data); end
    void'(sb.pop_front());
    @(negedge clk); reset = 1'b0;
    writes = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (wb_we === 1'b1 || done === 1'b1 || busy === 1'b1) writes++;
    end
    n_tests++; if (writes !== 0) begin n_fail++; $display("FAIL abort_no_write got=%0d exp=0", writes); end
    issue(2'b10, 32'd9, 32'd3, 5'd10);
    wait_wb(0, found, lat, bn, d, a, w, dnx, wnx, bnx, dn);
    e = sb.pop_front();
    n_tests++; if (!found) begin n_fail++; $display("FAIL after_abort_timeout no done"); end
    n_tests++; if (lat !== e.lat) begin n_fail++; $display("FAIL after_abort_latency got=%0d exp=%0d", lat, e.lat); end
    n_tests++; if (d !== e.data || e.data !== 32'd3) begin n_fail++; $display("FAIL after_abort_data got=%0d exp=3", d); end
    n_tests++; if (a !== 5'd10 || w !== 1'b1) begin n_fail++; $display("FAIL after_abort_wb addr=%0d we=%b exp addr=10 we=1", a, w); end
  endtask

  task automatic test_random();
    bit found; int lat, bn; logic [31:0] d, dn; logic [4:0] a; logic w, dnx, wnx, bnx; exp_t e;
    logic [31:0] ra, rb;
    for (int k = 0; k < 8; k++) begin
      ra = $urandom;
      rb = (k % 4 == 3) ? 32'd0 : ((k % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom);
      issue(2'($urandom_range(0, 3)), ra, rb, 5'($urandom_range(0, 31)));
      wait_wb(0, found, lat, bn, d, a, w, dnx, wnx, bnx, dn);
      e = sb.pop_front();
      n_tests++; if (!found) begin n_fail++; $display("FAIL rand_%0d_timeout no done", k); end
      n_tests++; if (lat !== e.lat) begin n_fail++; $display("FAIL rand_%0d_latency got=%0d exp=%0d", k, lat, e.lat); end
      n_tests++; if (d !== e.data) begin n_fail++; $display("FAIL rand_%0d_data got=%h exp=%h", k, d, e.data); end
      n_tests++; if (a !== e.addr || w !== e.we) begin n_fail++; $display("FAIL rand_%0d_wb addr=%0d we=%b exp addr=%0d we=%b", k, a, w, e.addr, e.we); end
    end
  endtask

  initial begin
    logic [1:0]  t_op[4];
    logic [31:0] t_a[4];
    logic [31:0] t_b[4];
    logic [4:0]  t_rd[4];

    test_reset();
    test_mul_latency();

    t_op = '{2'b01, 2'b00, 2'b00, 2'b00};
    t_a  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
    t_b  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
    t_rd = '{5'd5, 5'd5, 5'd0, 5'd0};
    test_table("mul_wide", 2, t_op, t_a, t_b, t_rd);

    t_op = '{2'b10, 2'b11, 2'b00, 2'b00};
    t_a  = '{32'd100, 32'd100, 32'd0, 32'd0};
    t_b  = '{32'd7, 32'd7, 32'd0, 32'd0};
    t_rd = '{5'd8, 5'd8, 5'd0, 5'd0};
    test_table("div_b2b", 2, t_op, t_a, t_b, t_rd);

    t_op = '{2'b10, 2'b11, 2'b00, 2'b00};
    t_a  = '{32'h1234, 32'h1234, 32'd0, 32'd0};
    t_b  = '{32'd0, 32'd0, 32'd0, 32'd0};
    t_rd = '{5'd9, 5'd9, 5'd0, 5'd0};
    test_table("div_zero", 2, t_op, t_a, t_b, t_rd);

    t_op = '{2'b00, 2'b00, 2'b00, 2'b00};
    t_a  = '{32'd3, 32'd0, 32'd0, 32'd0};
    t_b  = '{32'd4, 32'd0, 32'd0, 32'd0};
    t_rd = '{5'd0, 5'd0, 5'd0, 5'd0};
    test_table("x0", 1, t_op, t_a, t_b, t_rd);

    test_ignore_start();
    test_abort();
    test_random();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
